// File: rtl/vca.sv
// vca: per-voice amplifier with slew-limited gain.
// Serial shift-add multiply, one multiplier bit per clk.
module vca #(
  parameter int BITDEPTH = 14,
  parameter int SLEW     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_clock,
  input  logic signed [BITDEPTH-1:0] sample_in,
  input  logic        [7:0]          volume,
  output logic signed [BITDEPTH-1:0] sample_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW = BITDEPTH + 9;
  localparam logic [7:0] SLEW_B = 8'(SLEW);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [BITDEPTH-1:0] mcand;
  logic        [7:0]          mplier;
  logic        [7:0]          vol_cur;
  logic        [7:0]          vol_nx;
  logic        [7:0]          gap;
  logic        [7:0]          step;
  logic        [2:0]          cnt;
  logic signed [AW-1:0]       acc;
  logic signed [AW-1:0]       term;
  logic signed [AW-1:0]       sum;
  logic                       start;
  logic                       last;

  assign busy  = (state != IDLE);
  assign start = (state == IDLE) && sample_clock;
  assign last  = (state == MUL) && (cnt == 3'd7);

  // Gain step toward volume, clamped to SLEW per strobe
  always_comb begin
    gap    = '0;
    step   = '0;
    vol_nx = vol_cur;
    if (volume > vol_cur) begin
      gap    = volume - vol_cur;
      step   = (gap > SLEW_B) ? SLEW_B : gap;
      vol_nx = vol_cur + step;
    end else if (volume < vol_cur) begin
      gap    = vol_cur - volume;
      step   = (gap > SLEW_B) ? SLEW_B : gap;
      vol_nx = vol_cur - step;
    end
  end

  // Partial product for the current multiplier bit
  always_comb begin
    term = '0;
    if (mplier[cnt])
      term = {{9{mcand[BITDEPTH-1]}}, mcand} <<< cnt;
    sum = acc + term;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (sample_clock) state_nx = MUL;
      MUL:  if (cnt == 3'd7)  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture, accumulate, and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand      <= '0;
      mplier     <= '0;
      vol_cur    <= '0;
      cnt        <= '0;
      acc        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= last;
      if (sample_clock && busy)
        overrun <= 1'b1;
      if (start) begin
        mcand   <= sample_in;
        vol_cur <= vol_nx;
        mplier  <= vol_nx;
        acc     <= '0;
        cnt     <= '0;
      end else if (state == MUL) begin
        acc <= sum;
        cnt <= cnt + 3'd1;
        if (last)
          sample_out <= BITDEPTH'(sum >>> 8);
      end
    end
  end

endmodule

// File: tb/tb_vca.sv
// tb_vca: directed checks of vca math, slew,
// timing, overrun and reset behaviour.
`timescale 1ns/1ps
module tb_vca;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              stb_f, stb_s;
  logic signed [13:0] in_f, in_s;
  logic        [7:0]  vol_f, vol_s;
  logic signed [13:0] out_f, out_s;
  logic              ov_f, ov_s;
  logic              busy_f, busy_s;
  logic              orun_f, orun_s;

  int checks = 0;
  int errors = 0;

  vca #(.BITDEPTH(14), .SLEW(255)) u_fast (
    .clk          (clk),
    .rst          (rst),
    .sample_clock (stb_f),
    .sample_in    (in_f),
    .volume       (vol_f),
    .sample_out   (out_f),
    .out_valid    (ov_f),
    .busy         (busy_f),
    .overrun      (orun_f)
  );

  vca #(.BITDEPTH(14), .SLEW(8)) u_slew (
    .clk          (clk),
    .rst          (rst),
    .sample_clock (stb_s),
    .sample_in    (in_s),
    .volume       (vol_s),
    .sample_out   (out_s),
    .out_valid    (ov_s),
    .busy         (busy_s),
    .overrun      (orun_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe; returns result and edge count (edge N = 1)
  task automatic run(input bit sel, input int sin, input int vol,
                     output int res, output int lat);
    int v;
    @(negedge clk);
    if (sel) begin
      stb_s = 1'b1; in_s = sin[13:0]; vol_s = vol[7:0];
    end else begin
      stb_f = 1'b1; in_f = sin[13:0]; vol_f = vol[7:0];
    end
    @(posedge clk);
    #1;
    stb_f = 1'b0;
    stb_s = 1'b0;
    in_f  = 14'sd0;
    in_s  = 14'sd0;
    lat = 1;
    res = -99999;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      v = sel ? int'(ov_s) : int'(ov_f);
      if (v == 1) begin
        res = sel ? int'(out_s) : int'(out_f);
        break;
      end
    end
    @(posedge clk);
    #1;
    v = sel ? int'(ov_s) : int'(ov_f);
    chk("valid_fall", v, 0);
  endtask

  int sin_t [4] = '{8191, -8192, -1, 1000};
  int vol_t [4] = '{255, 255, 1, 0};
  int exp_t [4] = '{8159, -8160, -1, 0};

  initial begin
    int res, lat, nv, g, d;
    stb_f = 0; stb_s = 0;
    in_f = 0; in_s = 0;
    vol_f = 0; vol_s = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", int'(out_f), 0);
    chk("rst_valid", int'(ov_f), 0);
    chk("rst_busy", int'(busy_f), 0);
    chk("rst_orun", int'(orun_f), 0);
    chk("rst_out_s", int'(out_s), 0);
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      nv += int'(ov_f) + int'(ov_s);
    end
    chk("idle_no_valid", nv, 0);

    for (int i = 0; i < 4; i++) begin
      run(1'b0, sin_t[i], vol_t[i], res, lat);
      chk($sformatf("math%0d", i), res, exp_t[i]);
      chk($sformatf("lat%0d", i), lat, 9);
    end

    // Overrun: strobe at N, N+5 dropped, N+10 accepted
    chk("orun_pre", int'(orun_f), 0);
    @(negedge clk);
    stb_f = 1'b1; in_f = 14'sd100; vol_f = 8'd255;
    @(posedge clk);
    #1;
    stb_f = 1'b0;
    chk("busy_rise", int'(busy_f), 1);
    nv = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      nv += int'(ov_f);
    end
    @(negedge clk);
    stb_f = 1'b1; in_f = -14'sd5000; vol_f = 8'd0;
    @(posedge clk);
    #1;
    stb_f = 1'b0;
    nv += int'(ov_f);
    repeat (4) begin
      @(posedge clk);
      #1;
      nv += int'(ov_f);
    end
    chk("orun_one_valid", nv, 1);
    chk("orun_result", int'(out_f), 99);
    chk("orun_set", int'(orun_f), 1);
    chk("orun_idle", int'(busy_f), 0);
    run(1'b0, 100, 255, res, lat);
    chk("after_orun", res, 99);
    chk("after_orun_lat", lat, 9);
    chk("orun_sticky", int'(orun_f), 1);

    // Reset during 4th MUL cycle
    @(negedge clk);
    stb_f = 1'b1; in_f = 14'sd8191; vol_f = 8'd255;
    @(posedge clk);
    #1;
    stb_f = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_out", int'(out_f), 0);
    chk("mid_rst_busy", int'(busy_f), 0);
    chk("mid_rst_orun", int'(orun_f), 0);
    chk("mid_rst_valid", int'(ov_f), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 8191, 255, res, lat);
    chk("post_rst", res, 8159);
    chk("post_rst_lat", lat, 9);

    // Slew up 0 -> 100 in steps of 8
    g = 0;
    for (int i = 0; i < 13; i++) begin
      d = 100 - g;
      g += (d > 8) ? 8 : d;
      run(1'b1, 1000, 100, res, lat);
      chk($sformatf("up%0d_g%0d", i, g), res, (1000 * g) >>> 8);
      if (i == 0) chk("up_first", res, 31);
      if (i == 12) chk("up_last", res, 390);
    end
    run(1'b1, 1000, 100, res, lat);
    chk("up_hold", res, 390);

    // Slew down 100 -> 0
    for (int i = 0; i < 13; i++) begin
      g -= (g > 8) ? 8 : g;
      run(1'b1, 1000, 0, res, lat);
      chk($sformatf("dn%0d_g%0d", i, g), res, (1000 * g) >>> 8);
    end
    chk("dn_zero", res, 0);
    run(1'b1, 1000, 0, res, lat);
    chk("zero_hold", res, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vca.md
# vca

Voltage-controlled amplifier stage for one synth voice. Sits directly downstream of the envelope generator: on every `sample_clock` strobe it captures the oscillator sample and the envelope `volume`, slew-limits the gain to suppress zipper noise, and scales the sample with a serial shift-add multiplier. The scaled sample then goes to the voice mixer.

## Interface
- `BITDEPTH`, default 14: width of the signed sample in and out.
- `SLEW`, default 8: maximum change of the applied gain per sample strobe, 1..255. A value of 255 disables smoothing.
- `clk`  in  1: system clock, 8 MHz.
- `rst`  in  1: asynchronous, active-low reset.
- `sample_clock`  in  1: one-`clk`-wide strobe in the `clk` domain, from `sample_clock`.
- `sample_in`  in  BITDEPTH: signed oscillator sample.
- `volume`  in  8: unsigned envelope level, 0..255.
- `sample_out`  out  BITDEPTH: signed scaled sample.
- `out_valid`  out  1: one-cycle pulse when `sample_out` updates.
- `busy`  out  1: high while a multiply is in progress.
- `overrun`  out  1: sticky; set when a strobe arrives while `busy`.

## Operation
- Reset (`rst`=0, asynchronous), applied at any time including mid-multiply:
  - state returns to IDLE;
  - `sample_out`=0, `out_valid`=0, `busy`=0, `overrun`=0;
  - applied gain `vol_cur`=0, bit counter=0.
- States:
  - IDLE: waits for `sample_clock`=1.
  - MUL: 8 iterations, one per cycle.
  - DONE: 1 cycle.
- IDLE -> MUL on strobe. In the same edge:
  - capture `sample_in` into the multiplicand;
  - update `vol_cur` toward `volume`: if `volume`>`vol_cur`, `vol_cur` += min(`SLEW`, `volume`-`vol_cur`); if less, subtract symmetrically; if equal, no change;
  - latch the updated `vol_cur` as the multiplier;
  - clear the accumulator.
- MUL:
  - multiplier bits are processed LSB first.
  - The accumulator is signed and BITDEPTH+9 bits wide.
  - Iteration k adds (multiplicand <<< k) when multiplier bit k=1.
  - MUL -> DONE after iteration 7.
- DONE:
  - `sample_out` = accumulator >>> 8, an arithmetic shift that floors toward negative infinity. The result is 255/256 gain at full volume and never overflows BITDEPTH.
  - `out_valid`=1 for this cycle only. DONE -> IDLE.
- `busy`=1 in MUL and DONE, 0 in IDLE.
- Strobe while `busy`: ignored. No capture and no `vol_cur` update. `overrun` is set and stays set until reset.
- `sample_out` holds its value between results. `volume` and `sample_in` changes outside the capture edge have no effect.
- `volume`=0 with `vol_cur`=0 gives `sample_out`=0 exactly.

## Timing
- Strobe high at rising edge N:
  - `busy` rises after edge N;
  - MUL occupies edges N+1..N+8;
  - `sample_out` updates and `out_valid` rises after edge N+8, and `out_valid` falls after N+9.
- Latency from strobe to `out_valid` is 9 cycles. Throughput is one sample per 10 cycles minimum. The normal strobe period is 256 cycles, so `overrun` never sets in normal use.
- A strobe at edge N+9 (`busy` still high) is dropped. A strobe at N+10 or later is accepted.
- The `vol_cur` step size uses the `volume` value at the capture edge only.

## Test plan
- Reset: hold `rst`=0, then release. Required: all outputs 0, no `out_valid` without a strobe. Assert `rst`=0 at cycle 4 of MUL: outputs clear immediately, and the next strobe after release produces a normal result.
- Exact math, `SLEW`=255:
  - `sample_in`=8191, `volume`=255 -> `sample_out`=8159;
  - `sample_in`=-8192, `volume`=255 -> -8160;
  - `sample_in`=-1, `volume`=1 -> -1;
  - `sample_in`=1000, `volume`=0 -> 0.
  - Each case: `out_valid` pulses exactly 9 cycles after the strobe.
- Slew, `SLEW`=8, `volume` stepping 0 -> 100, `sample_in`=1000:
  - successive applied gains 8, 16, …, 96, 100 (13 strobes);
  - first output 31;
  - 13th and later outputs 390.
  - Then `volume`=0: gains descend 92, 84, …, 4, 0.
- Overrun: strobe at N and N+5 -> one `out_valid` only, `overrun`=1 thereafter. Strobe at N+10 -> accepted normally.
- Envelope-driven run: connect `envelope` with gate high for 30 ms then low, `a`=255, `r`=30, constant `sample_in`=4000.
  - `sample_out` is monotonic non-decreasing during attack and non-increasing during release.
  - It never exceeds 3984.
  - It reaches 0 after release completes.
